srl_delay_ctrl: RTL and testbench

- Sequencing controller for a runtime-programmable, addressable shift-register delay line (external SRL with clock-enable, data-in and tap-address inputs).
- Owns tap-address selection, line flushing to a known fill value, and prime tracking, so downstream sees a valid qualifier only once the line holds D real samples.
- Reconfiguration arrives via a valid/ready handshake. Sits between the sample source and the SRL primitive in the delay datapath.

---
 rtl/srl_delay_ctrl_pkg.sv | 26 ++
 rtl/srl_delay_ctrl_if.sv | 26 ++
 rtl/srl_delay_ctrl.sv | 123 ++++++++++++
 tb/tb_srl_delay_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_delay_ctrl_pkg.sv
// rtl/srl_delay_ctrl_pkg.sv - shared states, defaults and clamp helper for srl_delay_ctrl
package srl_ctrl_pkg;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int   DEF_MAX_DELAY     = 128;
  localparam int   DEF_ADDR_W        = 7;
  localparam int   DEF_DEFAULT_DELAY = 128;
  localparam logic DEF_FILL_VALUE    = 1'b1;

  // Legal delays are 1..max_delay; out-of-range requests snap to the nearest end.
  function automatic int unsigned clamp_delay(input int unsigned value,
                                              input int unsigned max_delay);
    if (value == 0)
      return 1;
    else if (value > max_delay)
      return max_delay;
    else
      return value;
  endfunction

endpackage

// File: rtl/srl_delay_ctrl_if.sv
// rtl/srl_delay_ctrl_if.sv - sample stream and reconfiguration handshake bundle
interface srl_delay_ctrl_if
  import srl_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              id;
  logic              id_valid;
  logic              oready;
  logic              icfg_valid;
  logic [ADDR_W:0]   icfg_delay;
  logic              ocfg_ready;
  logic              ocfg_err;

  modport master (
    output id, id_valid, icfg_valid, icfg_delay,
    input  oready, ocfg_ready, ocfg_err
  );

  modport slave (
    input  id, id_valid, icfg_valid, icfg_delay,
    output oready, ocfg_ready, ocfg_err
  );

endinterface

// File: rtl/srl_delay_ctrl.sv
// rtl/srl_delay_ctrl.sv - flush/fill/run sequencer for an addressable SRL delay line
module srl_delay_ctrl
  import srl_ctrl_pkg::*;
#(
  parameter int   MAX_DELAY     = DEF_MAX_DELAY,
  parameter int   ADDR_W        = DEF_ADDR_W,
  parameter int   DEFAULT_DELAY = DEF_DEFAULT_DELAY,
  parameter logic FILL_VALUE    = DEF_FILL_VALUE
) (
  input  logic                  iclk,
  input  logic                  ireset_n,
  srl_delay_ctrl_if.slave       bus,
  input  logic                  iflush,
  output logic                  osrl_ce,
  output logic                  osrl_d,
  output logic [ADDR_W-1:0]     osrl_addr,
  output logic                  ovalid,
  output logic                  obusy
);

  localparam int DW = ADDR_W + 1;

  state_t          state_q, state_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [DW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic            err_q, err_d;
  logic [DW-1:0]   cfg_clamped;
  logic            cfg_take;
  logic            restart;

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state_q     <= S_FLUSH;
      delay_q     <= DW'(DEFAULT_DELAY);
      addr_q      <= ADDR_W'(DEFAULT_DELAY - 1);
      flush_cnt_q <= '0;
      fill_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      addr_q      <= ADDR_W'(delay_d - 1'b1);
      flush_cnt_q <= flush_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    flush_cnt_d    = flush_cnt_q;
    fill_cnt_d     = fill_cnt_q;
    err_d          = 1'b0;
    osrl_ce        = 1'b0;
    osrl_d         = FILL_VALUE;
    ovalid         = 1'b0;
    bus.oready     = 1'b0;
    bus.ocfg_ready = 1'b0;
    cfg_take       = 1'b0;
    restart        = 1'b0;
    cfg_clamped    = DW'(clamp_delay(32'(bus.icfg_delay), unsigned'(MAX_DELAY)));

    case (state_q)
      S_FLUSH: begin
        // Flush always covers the full line so every stage holds FILL_VALUE.
        osrl_ce = 1'b1;
        osrl_d  = FILL_VALUE;
        if (flush_cnt_q == DW'(MAX_DELAY - 1)) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      S_FILL, S_RUN: begin
        bus.oready     = 1'b1;
        bus.ocfg_ready = 1'b1;
        osrl_ce        = bus.id_valid;
        osrl_d         = bus.id;
        ovalid         = (state_q == S_RUN) && bus.id_valid;

        if ((state_q == S_FILL) && bus.id_valid) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_d == delay_q)
            state_d = S_RUN;
        end

        cfg_take = bus.icfg_valid;
        restart  = cfg_take || iflush;
        if (cfg_take) begin
          delay_d = cfg_clamped;
          err_d   = (cfg_clamped != bus.icfg_delay);
        end
        // A config and a flush request in one cycle share a single flush.
        if (restart) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end
      end

      default: begin
        state_d     = S_FLUSH;
        flush_cnt_d = '0;
      end
    endcase

    if (!ireset_n) begin
      osrl_ce        = 1'b0;
      ovalid         = 1'b0;
      bus.oready     = 1'b0;
      bus.ocfg_ready = 1'b0;
    end
  end

  assign osrl_addr    = addr_q;
  assign bus.ocfg_err = err_q;
  assign obusy        = (state_q == S_FLUSH) || (state_q == S_FILL);

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// tb/tb_srl_delay_ctrl.sv - scoreboard bench for srl_delay_ctrl driving a behavioural SRL
module srl_dyn_line #(
  parameter int MAX_DELAY = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              d,
  input  logic [ADDR_W-1:0] addr,
  output logic              q
);
  logic [MAX_DELAY-1:0] sr;
  always_ff @(posedge clk)
    if (ce) sr <= {sr[MAX_DELAY-2:0], d};
  assign q = sr[addr];
endmodule

module tb_srl_delay_ctrl;

  localparam int MAXD = 128;
  localparam int AW   = 7;

  typedef struct packed {
    logic v;
    logic q;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          iflush;
  logic          osrl_ce, osrl_d, ovalid, obusy, q;
  logic [AW-1:0] osrl_addr;

  srl_delay_ctrl_if #(.ADDR_W(AW)) bus();

  srl_delay_ctrl #(
    .MAX_DELAY(MAXD), .ADDR_W(AW), .DEFAULT_DELAY(128), .FILL_VALUE(1'b1)
  ) dut (
    .iclk(clk), .ireset_n(rst_n), .bus(bus), .iflush(iflush),
    .osrl_ce(osrl_ce), .osrl_d(osrl_d), .osrl_addr(osrl_addr),
    .ovalid(ovalid), .obusy(obusy)
  );

  srl_dyn_line #(.MAX_DELAY(MAXD), .ADDR_W(AW)) line (
    .clk(clk), .ce(osrl_ce), .d(osrl_d), .addr(osrl_addr), .q(q)
  );

  exp_t exp_q[$];
  logic hist[$];
  int   m_delay;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of sample input and records what the tap must show.
  task automatic drive_strobe(input logic val, input logic data);
    exp_t e;
    bus.id_valid = val;
    bus.id       = data;
    e.v = val && (hist.size() >= m_delay);
    e.q = e.v ? hist[hist.size() - m_delay] : 1'b0;
    exp_q.push_back(e);
    if (val) hist.push_back(data);
  endtask

  // Waits out a flush (bounded); reports its length and whether outputs stayed flush-like.
  task automatic wait_flush(input bit pulse, output int cycles, output bit clean);
    cycles = 0;
    clean  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.id_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.id       = 1'($urandom);
      @(negedge clk);
      if (bus.oready) begin
        bus.id_valid   = 1'b0;
        bus.icfg_valid = 1'b0;
        step();
        break;
      end
      if (!(osrl_ce && osrl_d && !bus.ocfg_ready && obusy && !ovalid)) clean = 1'b0;
      cycles++;
      step();
    end
    bus.id_valid   = 1'b0;
    bus.icfg_valid = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    int cyc;
    bit clean;
    rst_n = 1'b0; iflush = 1'b1;
    bus.id_valid = 1'b1; bus.id = 1'b1; bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd5;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if ({osrl_ce, ovalid, bus.oready, bus.ocfg_ready} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_forced: ce/valid/ready/cfg_ready=%b expected 0000",
               {osrl_ce, ovalid, bus.oready, bus.ocfg_ready});
    end
    iflush = 1'b0; bus.id_valid = 1'b0; bus.icfg_valid = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (osrl_addr !== 7'd127 || bus.ocfg_err !== 1'b0 || obusy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: addr=%0d err=%b busy=%b expected 127 0 1", osrl_addr, bus.ocfg_err, obusy);
    end
    wait_flush(1'b0, cyc, clean);
    n_checks++;
    if (cyc !== 128 || !clean) begin
      n_errors++;
      $display("FAIL reset_flush: cycles=%0d clean=%b expected 128 1", cyc, clean);
    end
    @(negedge clk);
    n_checks++;
    if (q !== 1'b1 || obusy !== 1'b1) begin
      n_errors++;
      $display("FAIL line_filled: q=%b busy=%b expected 1 1", q, obusy);
    end
    step();
    m_delay = 128;
  endtask

  task automatic test_fill_128();
    exp_t e;
    for (int i = 0; i < 168; i++) begin
      drive_strobe(1'b1, logic'(i[1] ^ i[4]));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ovalid !== e.v || (e.v && q !== e.q)) begin
        n_errors++;
        $display("FAIL fill128_strobe[%0d]: ovalid=%b q=%b expected %b %b", i, ovalid, q, e.v, e.q);
      end
      if (i == 127 || i == 128) begin
        n_checks++;
        if (obusy !== (i == 127)) begin
          n_errors++;
          $display("FAIL fill128_busy[%0d]: busy=%b expected %b", i, obusy, (i == 127));
        end
      end
      step();
    end
    bus.id_valid = 1'b0;
  endtask

  task automatic test_cfg_d5();
    exp_t e;
    int   cyc;
    bit   clean;
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd5;
    @(negedge clk);
    n_checks++;
    if (bus.ocfg_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg5_ready: ocfg_ready=%b expected 1", bus.ocfg_ready);
    end
    step();
    bus.icfg_valid = 1'b0;
    n_checks++;
    if (osrl_addr !== 7'd4 || bus.ocfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg5_addr: addr=%0d err=%b expected 4 0", osrl_addr, bus.ocfg_err);
    end
    m_delay = 5;
    wait_flush(1'b1, cyc, clean);
    n_checks++;
    if (cyc !== 128 || !clean) begin
      n_errors++;
      $display("FAIL cfg5_flush: cycles=%0d clean=%b expected 128 1", cyc, clean);
    end
    for (int i = 0; i < 80; i++) begin
      drive_strobe(logic'($urandom_range(0, 3) != 0), 1'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ovalid !== e.v || (e.v && q !== e.q)) begin
        n_errors++;
        $display("FAIL d5_strobe[%0d]: ovalid=%b q=%b expected %b %b", i, ovalid, q, e.v, e.q);
      end
      step();
    end
    bus.id_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   clean;
    drive_strobe(1'b1, 1'($urandom));
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd3; iflush = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (ovalid !== e.v || e.v !== 1'b1 || q !== e.q || osrl_ce !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_strobe: ovalid=%b q=%b ce=%b expected 1 %b 1", ovalid, q, osrl_ce, e.q);
    end
    step();
    bus.icfg_valid = 1'b0; iflush = 1'b0; bus.id_valid = 1'b0;
    n_checks++;
    if (osrl_addr !== 7'd2 || bus.ocfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL same_cycle_addr: addr=%0d err=%b expected 2 0", osrl_addr, bus.ocfg_err);
    end
    m_delay = 3;
    wait_flush(1'b0, cyc, clean);
    n_checks++;
    if (cyc !== 128 || !clean) begin
      n_errors++;
      $display("FAIL same_cycle_flush: cycles=%0d clean=%b expected 128 1", cyc, clean);
    end
    for (int i = 0; i < 30; i++) begin
      drive_strobe(logic'($urandom_range(0, 2) != 0), 1'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ovalid !== e.v || (e.v && q !== e.q)) begin
        n_errors++;
        $display("FAIL d3_strobe[%0d]: ovalid=%b q=%b expected %b %b", i, ovalid, q, e.v, e.q);
      end
      step();
    end
    bus.id_valid = 1'b0;
  endtask

  task automatic test_clamp();
    exp_t e;
    int   cyc;
    bit   clean;
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd0;
    step();
    bus.icfg_valid = 1'b0;
    n_checks++;
    if (bus.ocfg_err !== 1'b1 || osrl_addr !== 7'd0) begin
      n_errors++;
      $display("FAIL clamp0: err=%b addr=%0d expected 1 0", bus.ocfg_err, osrl_addr);
    end
    step();
    n_checks++;
    if (bus.ocfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL clamp0_pulse: err=%b expected 0", bus.ocfg_err);
    end
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd7;
    wait_flush(1'b1, cyc, clean);
    n_checks++;
    if (cyc !== 127 || !clean || osrl_addr !== 7'd0) begin
      n_errors++;
      $display("FAIL flush_ignores_cfg: cycles=%0d clean=%b addr=%0d expected 127 1 0", cyc, clean, osrl_addr);
    end
    m_delay = 1;
    for (int i = 0; i < 24; i++) begin
      drive_strobe((i == 0) ? 1'b1 : logic'($urandom_range(0, 2) != 0), 1'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ovalid !== e.v || (e.v && q !== e.q)) begin
        n_errors++;
        $display("FAIL d1_strobe[%0d]: ovalid=%b q=%b expected %b %b", i, ovalid, q, e.v, e.q);
      end
      step();
      if (i == 0) begin
        n_checks++;
        if (obusy !== 1'b0) begin
          n_errors++;
          $display("FAIL d1_run: busy=%b expected 0", obusy);
        end
      end
    end
    bus.id_valid = 1'b0;
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd200;
    step();
    bus.icfg_valid = 1'b0;
    n_checks++;
    if (bus.ocfg_err !== 1'b1 || osrl_addr !== 7'd127) begin
      n_errors++;
      $display("FAIL clamp200: err=%b addr=%0d expected 1 127", bus.ocfg_err, osrl_addr);
    end
    step();
    wait_flush(1'b0, cyc, clean);
    m_delay = 128;
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd128;
    step();
    bus.icfg_valid = 1'b0;
    n_checks++;
    if (bus.ocfg_err !== 1'b0 || osrl_addr !== 7'd127) begin
      n_errors++;
      $display("FAIL cfg128_no_err: err=%b addr=%0d expected 0 127", bus.ocfg_err, osrl_addr);
    end
    wait_flush(1'b0, cyc, clean);
  endtask

  task automatic test_reset_mid_fill();
    exp_t e;
    int   cyc;
    bit   clean;
    bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd10;
    step();
    bus.icfg_valid = 1'b0;
    wait_flush(1'b0, cyc, clean);
    m_delay = 10;
    for (int i = 0; i < 4; i++) begin
      drive_strobe(1'b1, 1'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      step();
    end
    rst_n = 1'b0; bus.id_valid = 1'b1; bus.icfg_valid = 1'b1; bus.icfg_delay = 8'd20;
    @(negedge clk);
    n_checks++;
    if ({osrl_ce, ovalid, bus.oready, bus.ocfg_ready} !== 4'b0000) begin
      n_errors++;
      $display("FAIL midfill_forced: ce/valid/ready/cfg_ready=%b expected 0000",
               {osrl_ce, ovalid, bus.oready, bus.ocfg_ready});
    end
    step();
    rst_n = 1'b1; bus.id_valid = 1'b0; bus.icfg_valid = 1'b0;
    n_checks++;
    if (obusy !== 1'b1 || osrl_addr !== 7'd127 || bus.ocfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midfill_reset_state: busy=%b addr=%0d err=%b expected 1 127 0", obusy, osrl_addr, bus.ocfg_err);
    end
    wait_flush(1'b0, cyc, clean);
    n_checks++;
    if (cyc !== 128 || !clean) begin
      n_errors++;
      $display("FAIL midfill_flush: cycles=%0d clean=%b expected 128 1", cyc, clean);
    end
    m_delay = 128;
    for (int i = 0; i < 140; i++) begin
      drive_strobe(1'b1, 1'($urandom));
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (ovalid !== e.v || (e.v && q !== e.q)) begin
        n_errors++;
        $display("FAIL midfill_refill[%0d]: ovalid=%b q=%b expected %b %b", i, ovalid, q, e.v, e.q);
      end
      step();
    end
    bus.id_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; iflush = 1'b0;
    bus.id = 1'b0; bus.id_valid = 1'b0; bus.icfg_valid = 1'b0; bus.icfg_delay = '0;
    m_delay = 128;
    test_reset();
    test_fill_128();
    test_cfg_d5();
    test_back_to_back();
    test_clamp();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
